// File: rtl/clock_core_param.sv
// clock_core_param: parameterised time-of-day core with sub-second counter,
// manual field adjust, 12/24-hour display, alarm and day-rollover pulses.
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         asynchronous active-high reset
//   i_run         1 = prescaler and time fields advance, 0 = hold
//   i_sel[1:0]    adjust target: 00 sec, 01 min, 10 hour, 11 none
//   i_inc, i_dec  single-cycle adjust pulses (+1 / -1 on selected field)
//   i_mode12      display format: 1 = 12-hour, 0 = 24-hour
//   i_alarm_en    alarm enable
//   i_alarm_min   alarm minute (0..59)
//   i_alarm_hour  alarm hour (0..23)
//   o_msec        sub-second count, 0..SUB_COUNT-1
//   o_sec, o_min  seconds / minutes, 0..59
//   o_hour        display hour (combinational from the internal hour)
//   o_pm          1 when the internal hour >= 12
//   o_alarm       one-cycle alarm pulse (registered)
//   o_day         one-cycle day-rollover pulse (registered)
module clock_core_param #(
  parameter int unsigned FCOUNT    = 1_000_000,
  parameter int unsigned SUB_COUNT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic [1:0] i_sel,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_mode12,
  input  logic       i_alarm_en,
  input  logic [5:0] i_alarm_min,
  input  logic [4:0] i_alarm_hour,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_alarm,
  output logic       o_day
);

  localparam int unsigned PW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;

  logic [PW-1:0] presc_q, presc_nxt;
  logic [6:0]    msec_q,  msec_nxt;
  logic [5:0]    sec_q,   sec_nxt;
  logic [5:0]    min_q,   min_nxt;
  logic [4:0]    hour_q,  hour_nxt;
  logic          alarm_q, alarm_nxt;
  logic          day_q,   day_nxt;

  logic tick, msec_wrap, sec_wrap, min_wrap, hour_wrap;
  logic adj_ok, adj_sec, adj_min, adj_hour;
  logic alarm_valid;

  // Modular +1 / -1 within 0..max, used by manual adjust only.
  function automatic logic [5:0] adj_step(input logic [5:0] v, input logic [5:0] max,
                                          input logic up);
    if (up) return (v == max) ? 6'd0 : 6'(v + 6'd1);
    else    return (v == 6'd0) ? max : 6'(v - 6'd1);
  endfunction

  // Same-cycle carry chain, evaluated from current register values.
  always_comb begin
    tick      = i_run && (presc_q == PW'(FCOUNT - 1));
    msec_wrap = tick && (msec_q == 7'(SUB_COUNT - 1));
    sec_wrap  = msec_wrap && (sec_q == 6'd59);
    min_wrap  = sec_wrap && (min_q == 6'd59);
    hour_wrap = min_wrap && (hour_q == 5'd23);
  end

  // Adjust decode: exactly one of inc/dec and a real target.
  always_comb begin
    adj_ok   = (i_inc ^ i_dec) && (i_sel != 2'b11);
    adj_sec  = adj_ok && (i_sel == 2'b00);
    adj_min  = adj_ok && (i_sel == 2'b01);
    adj_hour = adj_ok && (i_sel == 2'b10);
    alarm_valid = (i_alarm_min <= 6'd59) && (i_alarm_hour <= 5'd23);
  end

  // Next-state: counting first, then adjust overrides the selected field.
  always_comb begin
    presc_nxt = presc_q;
    msec_nxt  = msec_q;
    sec_nxt   = sec_q;
    min_nxt   = min_q;
    hour_nxt  = hour_q;
    alarm_nxt = 1'b0;
    day_nxt   = 1'b0;

    if (tick)       presc_nxt = '0;
    else if (i_run) presc_nxt = presc_q + PW'(1);

    if (msec_wrap) msec_nxt = 7'd0;
    else if (tick) msec_nxt = msec_q + 7'd1;

    if (sec_wrap)       sec_nxt = 6'd0;
    else if (msec_wrap) sec_nxt = sec_q + 6'd1;

    if (min_wrap)      min_nxt = 6'd0;
    else if (sec_wrap) min_nxt = min_q + 6'd1;

    if (hour_wrap)     hour_nxt = 5'd0;
    else if (min_wrap) hour_nxt = hour_q + 5'd1;

    // Adjust wins over any carry landing on the same field.
    if (adj_sec) begin
      sec_nxt   = adj_step(sec_q, 6'd59, i_inc);
      msec_nxt  = 7'd0;
      presc_nxt = '0;
    end
    if (adj_min)  min_nxt  = adj_step(min_q, 6'd59, i_inc);
    if (adj_hour) hour_nxt = 5'(adj_step(6'(hour_q), 6'd23, i_inc));

    // Alarm only on a carry-driven minute boundary, never on a manual set.
    alarm_nxt = i_alarm_en && sec_wrap && !adj_sec && alarm_valid &&
                (hour_nxt == i_alarm_hour) && (min_nxt == i_alarm_min);
    day_nxt   = hour_wrap && !adj_hour;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      msec_q  <= 7'd0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      alarm_q <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      presc_q <= presc_nxt;
      msec_q  <= msec_nxt;
      sec_q   <= sec_nxt;
      min_q   <= min_nxt;
      hour_q  <= hour_nxt;
      alarm_q <= alarm_nxt;
      day_q   <= day_nxt;
    end
  end

  // Display hour: 12-hour mode maps 0 -> 12 and 13..23 -> 1..11.
  always_comb begin
    o_hour = hour_q;
    if (i_mode12) begin
      if (hour_q == 5'd0)       o_hour = 5'd12;
      else if (hour_q > 5'd12)  o_hour = hour_q - 5'd12;
    end
  end

  assign o_pm    = (hour_q >= 5'd12);
  assign o_msec  = msec_q;
  assign o_sec   = sec_q;
  assign o_min   = min_q;
  assign o_alarm = alarm_q;
  assign o_day   = day_q;

endmodule

// File: tb/tb_clock_core_param.sv
// Directed testbench for clock_core_param with FCOUNT=2, SUB_COUNT=4.
module tb_clock_core_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_run;
  logic [1:0] i_sel;
  logic       i_inc;
  logic       i_dec;
  logic       i_mode12;
  logic       i_alarm_en;
  logic [5:0] i_alarm_min;
  logic [4:0] i_alarm_hour;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_pm;
  logic       o_alarm;
  logic       o_day;

  int total = 0;
  int bad   = 0;

  clock_core_param #(.FCOUNT(2), .SUB_COUNT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_run       (i_run),
    .i_sel       (i_sel),
    .i_inc       (i_inc),
    .i_dec       (i_dec),
    .i_mode12    (i_mode12),
    .i_alarm_en  (i_alarm_en),
    .i_alarm_min (i_alarm_min),
    .i_alarm_hour(i_alarm_hour),
    .o_msec      (o_msec),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hour      (o_hour),
    .o_pm        (o_pm),
    .o_alarm     (o_alarm),
    .o_day       (o_day)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [1:0] sel, input logic inc, input logic dec);
    i_sel = sel;
    i_inc = inc;
    i_dec = dec;
    step(1);
    i_inc = 1'b0;
    i_dec = 1'b0;
    i_sel = 2'b11;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_run = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int ms);
    chk({tag, ".hour"}, int'(o_hour), h);
    chk({tag, ".min"},  int'(o_min),  m);
    chk({tag, ".sec"},  int'(o_sec),  s);
    chk({tag, ".msec"}, int'(o_msec), ms);
  endtask

  initial begin
    reset = 1'b1;
    i_run = 1'b0;
    i_sel = 2'b11;
    i_inc = 1'b0;
    i_dec = 1'b0;
    i_mode12 = 1'b0;
    i_alarm_en = 1'b0;
    i_alarm_min = 6'd0;
    i_alarm_hour = 5'd0;

    // Reset state, before any clock edge.
    #3;
    chk_time("rst", 0, 0, 0, 0);
    chk("rst.pm", int'(o_pm), 0);
    chk("rst.alarm", int'(o_alarm), 0);
    chk("rst.day", int'(o_day), 0);
    i_mode12 = 1'b1;
    #1;
    chk("rst.hour12", int'(o_hour), 12);
    i_mode12 = 1'b0;

    // Free run: tick every 2nd cycle, 8 ticks -> 2 s.
    step(1);
    reset = 1'b0;
    i_run = 1'b1;
    step(1);
    chk("run.e1.msec", int'(o_msec), 0);
    step(1);
    chk("run.e2.msec", int'(o_msec), 1);
    step(14);
    chk("run.8tick.sec", int'(o_sec), 2);
    chk("run.8tick.msec", int'(o_msec), 0);
    i_run = 1'b0;
    step(3);
    chk("hold.sec", int'(o_sec), 2);

    // Preload 23:59:59.3 and roll over in one edge.
    do_reset();
    pulse(2'b10, 1'b0, 1'b1);
    pulse(2'b01, 1'b0, 1'b1);
    pulse(2'b00, 1'b0, 1'b1);
    i_run = 1'b1;
    step(6);
    chk_time("pre", 23, 59, 59, 3);
    chk("pre.day", int'(o_day), 0);
    step(2);
    i_run = 1'b0;
    chk_time("roll", 0, 0, 0, 0);
    chk("roll.day", int'(o_day), 1);
    step(1);
    chk("roll.day.next", int'(o_day), 0);

    // Adjust wrap without borrow/carry, and no-op cases.
    pulse(2'b01, 1'b0, 1'b1);
    chk("mindec.min", int'(o_min), 59);
    chk("mindec.hour", int'(o_hour), 0);
    pulse(2'b01, 1'b1, 1'b1);
    chk("both.min", int'(o_min), 59);
    pulse(2'b11, 1'b1, 1'b0);
    chk("selnone.min", int'(o_min), 59);
    pulse(2'b01, 1'b1, 1'b0);
    chk("mininc.min", int'(o_min), 0);
    chk("mininc.hour", int'(o_hour), 0);
    pulse(2'b10, 1'b0, 1'b1);
    chk("hourdec.hour", int'(o_hour), 23);
    pulse(2'b10, 1'b1, 1'b0);
    chk("hourinc.hour", int'(o_hour), 0);
    chk("hourinc.day", int'(o_day), 0);

    // Alarm at 07:30 via carry.
    do_reset();
    i_alarm_en = 1'b1;
    i_alarm_hour = 5'd7;
    i_alarm_min = 6'd30;
    for (int i = 0; i < 7; i++) pulse(2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) pulse(2'b01, 1'b0, 1'b1);
    pulse(2'b00, 1'b0, 1'b1);
    i_run = 1'b1;
    step(6);
    chk_time("alm.pre", 7, 29, 59, 3);
    chk("alm.pre.alarm", int'(o_alarm), 0);
    step(2);
    chk_time("alm.hit", 7, 30, 0, 0);
    chk("alm.hit.alarm", int'(o_alarm), 1);
    step(1);
    chk("alm.next.alarm", int'(o_alarm), 0);
    i_run = 1'b0;

    // Manual set onto the alarm time never fires.
    do_reset();
    for (int i = 0; i < 7; i++) pulse(2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) pulse(2'b01, 1'b1, 1'b0);
    chk("almman.min", int'(o_min), 30);
    chk("almman.alarm", int'(o_alarm), 0);
    step(1);
    chk("almman.alarm.next", int'(o_alarm), 0);
    i_alarm_en = 1'b0;

    // 12-hour display.
    do_reset();
    i_mode12 = 1'b1;
    #1;
    chk("h12.0.hour", int'(o_hour), 12);
    chk("h12.0.pm", int'(o_pm), 0);
    for (int i = 0; i < 12; i++) pulse(2'b10, 1'b1, 1'b0);
    chk("h12.12.hour", int'(o_hour), 12);
    chk("h12.12.pm", int'(o_pm), 1);
    pulse(2'b10, 1'b1, 1'b0);
    chk("h12.13.hour", int'(o_hour), 1);
    chk("h12.13.pm", int'(o_pm), 1);
    i_mode12 = 1'b0;
    #1;
    chk("h24.13.hour", int'(o_hour), 13);

    // Hour adjust collides with min->hour carry: adjust wins.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(2'b10, 1'b1, 1'b0);
    pulse(2'b01, 1'b0, 1'b1);
    pulse(2'b00, 1'b0, 1'b1);
    i_run = 1'b1;
    step(7);
    pulse(2'b10, 1'b0, 1'b1);
    chk_time("coll", 4, 0, 0, 0);

    // Asynchronous reset mid-run clears everything immediately.
    step(5);
    #2;
    reset = 1'b1;
    #1;
    chk_time("arst", 0, 0, 0, 0);
    chk("arst.pm", int'(o_pm), 0);
    chk("arst.day", int'(o_day), 0);
    chk("arst.alarm", int'(o_alarm), 0);
    step(1);
    reset = 1'b0;
    i_run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
